// File: rtl/pulse_ctrl_pkg.sv
// rtl/pulse_ctrl_pkg.sv - shared types and default widths for the pulse gate controller
//
// Purpose: state encoding and default parameter widths used by the controller,
//          its result interface and the dead-time filter.
// Contents:
//   state_e     IDLE / ARM / COUNT / REPORT
//   CNT_W_DEF   default pulse count width
//   WIN_W_DEF   default gate window width (clk cycles)
//   DEAD_W_DEF  default dead-time width (clk cycles)
package pulse_ctrl_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int WIN_W_DEF  = 24;
  localparam int DEAD_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_gate_controller_if.sv
// rtl/pulse_gate_controller_if.sv - count result valid/ready interface
//
// Purpose: carries the completed-run count from the controller to the readout logic.
// Signals:
//   count_data   count of the completed run
//   count_valid  count_data valid, held until count_ready
//   count_ready  consumer accepts count_data
//   overflow     count saturated during the run, valid with count_data
// Modports:
//   master  controller side (drives data/valid/overflow)
//   slave   consumer side (drives ready)
interface pulse_gate_controller_if
  import pulse_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] count_data;
  logic             count_valid;
  logic             count_ready;
  logic             overflow;

  modport master (
    output count_data,
    output count_valid,
    output overflow,
    input  count_ready
  );

  modport slave (
    input  count_data,
    input  count_valid,
    input  overflow,
    output count_ready
  );

endinterface

// File: rtl/pulse_gate_controller_dead_time_filter.sv
// rtl/pulse_gate_controller_dead_time_filter.sv - non-paralyzable dead-time pulse filter
//
// Purpose: accepts a pulse only when the dead counter is idle; an accepted pulse
//          reloads the counter with dead_time, dropped pulses do not extend it.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   clr        forces the dead counter to zero (used outside the counting window)
//   en         pulses are only considered while high
//   pulse_in   raw pulse, one cycle per event
//   dead_time  reload value after an accepted pulse
//   accept     combinational: this cycle's pulse is accepted
module dead_time_filter
  import pulse_ctrl_pkg::*;
#(
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              pulse_in,
  input  logic [DEAD_W-1:0] dead_time,
  output logic              accept
);

  logic [DEAD_W-1:0] dead_q;
  logic [DEAD_W-1:0] dead_d;

  assign accept = en && pulse_in && (dead_q == '0);

  // Countdown runs every cycle regardless of pulse activity; only an accepted
  // pulse reloads it, so a dropped pulse never stretches the dead window.
  always_comb begin
    dead_d = dead_q;
    if (clr) begin
      dead_d = '0;
    end else if (accept) begin
      dead_d = dead_time;
    end else if (dead_q != '0) begin
      dead_d = dead_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_q <= '0;
    end else begin
      dead_q <= dead_d;
    end
  end

endmodule

// File: rtl/pulse_gate_controller.sv
// rtl/pulse_gate_controller.sv - timed pulse counting run with dead-time filtering
//
// Purpose: on start, enables the pulse source, counts dead-time-filtered pulses for a
//          programmable window, then stops the source and reports the count on a
//          valid/ready handshake.
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   ena         block enable; low during ARM/COUNT aborts the run
//   start       single-cycle run request (honoured only in IDLE)
//   window_len  gate length in cycles, sampled on accepted start
//   dead_time   dead time after each accepted pulse, sampled on accepted start
//   pulse_in    raw pulse from the source
//   src_ena     pulse source enable (ARM and COUNT)
//   busy        high in every state except IDLE
//   pulse_out   one-cycle registered strobe per accepted pulse
//   count_if    result handshake (count_data/count_valid/count_ready/overflow)
module pulse_gate_controller
  import pulse_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int DEAD_W = DEAD_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  input  logic [WIN_W-1:0]          window_len,
  input  logic [DEAD_W-1:0]         dead_time,
  input  logic                      pulse_in,
  output logic                      src_ena,
  output logic                      busy,
  output logic                      pulse_out,
  pulse_gate_controller_if.master   count_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_e            state_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [DEAD_W-1:0] dead_time_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              src_ena_q;
  logic              busy_q;
  logic              pulse_out_q;
  logic              count_valid_q;
  logic              accept;

  // Filter is held cleared outside COUNT so every run starts with an open window.
  dead_time_filter #(
    .DEAD_W (DEAD_W)
  ) u_dead_time_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q != COUNT),
    .en        ((state_q == COUNT) && ena),
    .pulse_in  (pulse_in),
    .dead_time (dead_time_q),
    .accept    (accept)
  );

  // Saturating count; an accepted pulse at full scale only sets the sticky flag.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (accept) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      dead_time_q   <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      src_ena_q     <= 1'b0;
      busy_q        <= 1'b0;
      pulse_out_q   <= 1'b0;
      count_valid_q <= 1'b0;
    end else begin
      pulse_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && ena && (window_len != '0)) begin
            state_q     <= ARM;
            src_ena_q   <= 1'b1;
            busy_q      <= 1'b1;
            win_cnt_q   <= window_len;
            dead_time_q <= dead_time;
            count_q     <= '0;
            ovf_q       <= 1'b0;
          end
        end

        ARM: begin
          if (!ena) begin
            state_q   <= IDLE;
            src_ena_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            state_q <= COUNT;
          end
        end

        COUNT: begin
          if (!ena) begin
            // Abort: partial count is discarded so nothing stale is visible.
            state_q   <= IDLE;
            src_ena_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
          end else begin
            pulse_out_q <= accept;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            if (win_cnt_q == WIN_ONE) begin
              // Last window cycle: its pulse is counted on this same edge.
              state_q       <= REPORT;
              src_ena_q     <= 1'b0;
              count_valid_q <= 1'b1;
              win_cnt_q     <= '0;
            end else begin
              win_cnt_q <= win_cnt_q - 1'b1;
            end
          end
        end

        REPORT: begin
          if (count_if.count_ready) begin
            state_q       <= IDLE;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end

        default: begin
          state_q       <= IDLE;
          src_ena_q     <= 1'b0;
          busy_q        <= 1'b0;
          count_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign src_ena              = src_ena_q;
  assign busy                 = busy_q;
  assign pulse_out            = pulse_out_q;
  assign count_if.count_data  = count_q;
  assign count_if.count_valid = count_valid_q;
  assign count_if.overflow    = ovf_q;

endmodule
